// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line into the receiver, received byte, status pulses and FSM debug state out.
interface uart_rx_if;
  logic       i_RX_Serial;
  logic       o_RX_Active;
  logic       o_RX_DV;
  logic [7:0] o_RX_Byte;
  logic       o_RX_Frame_Err;
  logic [2:0] state_dbg;

  // o_RX_DV and o_RX_Frame_Err are one-cycle valid pulses with no ready/backpressure;
  // o_RX_Byte holds the last good byte until the next DV, so a consumer may read it late.
  modport slave (
    input  i_RX_Serial,
    output o_RX_Active, o_RX_DV, o_RX_Byte, o_RX_Frame_Err, state_dbg
  );

  modport master (
    output i_RX_Serial,
    input  o_RX_Active, o_RX_DV, o_RX_Byte, o_RX_Frame_Err, state_dbg
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, two-flop synchronizer, mid-bit sampling, DV / frame-error pulses.
// Define UART_RX_PARITY_EN to add a parity bit after the data bits (PARITY_ODD: 0 even, 1 odd).
module uart_rx #(
  parameter int CLKS_PER_BIT = 217
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic     i_Clock,
  input  logic     i_Rst,
  uart_rx_if.slave rx
);
  localparam int CW   = $clog2(CLKS_PER_BIT) + 1;
  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam logic [CW-1:0] HALF_CNT = CW'(HALF);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_BIT = 3'd1,
    DATA_BITS = 3'd2,
    STOP_BIT  = 3'd3,
    CLEANUP   = 3'd4,
    WAIT_IDLE = 3'd5
`ifdef UART_RX_PARITY_EN
    , PARITY_BIT = 3'd6
`endif
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] clock_count_q, clock_count_d;
  logic [2:0]    bit_index_q, bit_index_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rx_dv_q, rx_dv_d;
  logic          frame_err_q, frame_err_d;
  logic          rx_active_q, rx_active_d;
  logic          rx_bit;
  logic          bit_done;
  logic          stop_ok;
`ifdef UART_RX_PARITY_EN
  logic          parity_err_q, parity_err_d;
`endif

  assign rx_bit   = sync_q[1];
  assign bit_done = (clock_count_q == LAST_CNT);
  assign sync_d   = {sync_q[0], rx.i_RX_Serial};
`ifdef UART_RX_PARITY_EN
  assign stop_ok  = rx_bit && !parity_err_q;
`else
  assign stop_ok  = rx_bit;
`endif

  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      state_q       <= IDLE;
      sync_q        <= 2'b11;
      clock_count_q <= '0;
      bit_index_q   <= 3'd0;
      rx_data_q     <= 8'h00;
      rx_byte_q     <= 8'h00;
      rx_dv_q       <= 1'b0;
      frame_err_q   <= 1'b0;
      rx_active_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      sync_q        <= sync_d;
      clock_count_q <= clock_count_d;
      bit_index_q   <= bit_index_d;
      rx_data_q     <= rx_data_d;
      rx_byte_q     <= rx_byte_d;
      rx_dv_q       <= rx_dv_d;
      frame_err_q   <= frame_err_d;
      rx_active_q   <= rx_active_d;
`ifdef UART_RX_PARITY_EN
      parity_err_q  <= parity_err_d;
`endif
    end
  end

  // Next state plus the bit-timing datapath (counters, shift data).
  always_comb begin
    state_d       = state_q;
    clock_count_d = clock_count_q;
    bit_index_d   = bit_index_q;
    rx_data_d     = rx_data_q;
`ifdef UART_RX_PARITY_EN
    parity_err_d  = parity_err_q;
`endif
    case (state_q)
      IDLE: begin
        clock_count_d = '0;
        bit_index_d   = 3'd0;
`ifdef UART_RX_PARITY_EN
        parity_err_d  = 1'b0;
`endif
        if (!rx_bit) state_d = START_BIT;
      end
      START_BIT: begin
        if (clock_count_q == HALF_CNT) begin
          clock_count_d = '0;
          state_d       = rx_bit ? IDLE : DATA_BITS;
        end else begin
          clock_count_d = clock_count_q + 1'b1;
        end
      end
      DATA_BITS: begin
        if (!bit_done) begin
          clock_count_d = clock_count_q + 1'b1;
        end else begin
          clock_count_d          = '0;
          rx_data_d[bit_index_q] = rx_bit;
          if (bit_index_q == 3'd7) begin
            bit_index_d = 3'd0;
`ifdef UART_RX_PARITY_EN
            state_d     = PARITY_BIT;
`else
            state_d     = STOP_BIT;
`endif
          end else begin
            bit_index_d = bit_index_q + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY_BIT: begin
        if (!bit_done) begin
          clock_count_d = clock_count_q + 1'b1;
        end else begin
          clock_count_d = '0;
          parity_err_d  = ((^rx_data_q) ^ rx_bit) != PARITY_ODD;
          state_d       = STOP_BIT;
        end
      end
`endif
      STOP_BIT: begin
        if (!bit_done) begin
          clock_count_d = clock_count_q + 1'b1;
        end else begin
          clock_count_d = '0;
          state_d       = rx_bit ? CLEANUP : WAIT_IDLE;
        end
      end
      CLEANUP:   state_d = IDLE;
      WAIT_IDLE: if (rx_bit) state_d = IDLE;
      default: begin
        state_d       = IDLE;
        clock_count_d = '0;
        bit_index_d   = 3'd0;
      end
    endcase
  end

  // Registered outputs: DV and error default low so each is a single-cycle pulse.
  always_comb begin
    rx_dv_d     = 1'b0;
    frame_err_d = 1'b0;
    rx_active_d = rx_active_q;
    rx_byte_d   = rx_byte_q;
    case (state_q)
      START_BIT: if (clock_count_q == HALF_CNT && !rx_bit) rx_active_d = 1'b1;
      STOP_BIT: begin
        if (bit_done) begin
          if (stop_ok) begin
            rx_dv_d   = 1'b1;
            rx_byte_d = rx_data_q;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      DATA_BITS:  ;
`ifdef UART_RX_PARITY_EN
      PARITY_BIT: ;
`endif
      default: rx_active_d = 1'b0;
    endcase
  end

  assign rx.o_RX_Active    = rx_active_q;
  assign rx.o_RX_DV        = rx_dv_q;
  assign rx.o_RX_Byte      = rx_byte_q;
  assign rx.o_RX_Frame_Err = frame_err_q;
  assign rx.state_dbg      = state_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives serial frames into uart_rx and checks bytes, pulses and latency against a frame-level model.
module tb_uart_rx;
  localparam int CPB  = 8;
  localparam int HALF = (CPB - 1) / 2;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // Falling edge of the start bit to DV: 2 sync flops + half bit + 1 + all remaining bits.
  localparam int LAT_NOM = 2 + HALF + 1 + (FRAME_BITS - 1) * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  uart_rx_if rx_if ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock (clk),
    .i_Rst   (rst),
    .rx      (rx_if)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- monitor / scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int edge_cnt = 0;
  int dv_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int active_hi_cnt = 0;
  int dv_edge = 0;
  logic [7:0] obs_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] last_good = 8'h00;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(negedge clk) begin
    if (rx_if.o_RX_DV === 1'b1) begin
      dv_cnt++;
      dv_edge = edge_cnt;
      obs_q.push_back(rx_if.o_RX_Byte);
    end
    if (rx_if.o_RX_Frame_Err === 1'b1) err_cnt++;
    if (rx_if.o_RX_DV === 1'b1 && rx_if.o_RX_Frame_Err === 1'b1) both_cnt++;
    if (rx_if.o_RX_Active === 1'b1) active_hi_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic drive_bit(input logic b);
    rx_if.i_RX_Serial = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    rx_if.i_RX_Serial = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Sends one frame; counts bit starts (after the start bit) where Active was not high.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit, output int active_low);
    active_low = 0;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (rx_if.o_RX_Active !== 1'b1) active_low++;
      drive_bit(data[i]);
    end
`ifdef UART_RX_PARITY_EN
    if (rx_if.o_RX_Active !== 1'b1) active_low++;
    drive_bit(^data);
`endif
    if (rx_if.o_RX_Active !== 1'b1) active_low++;
    drive_bit(stop_bit);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int dv0, err0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx_if.i_RX_Serial = i[0];
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (rx_if.o_RX_Active !== 1'b0) begin n_errors++; $display("FAIL reset_active: got %b want 0", rx_if.o_RX_Active); end
    n_checks++;
    if (rx_if.o_RX_DV !== 1'b0) begin n_errors++; $display("FAIL reset_dv: got %b want 0", rx_if.o_RX_DV); end
    n_checks++;
    if (rx_if.o_RX_Frame_Err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b want 0", rx_if.o_RX_Frame_Err); end
    n_checks++;
    if (rx_if.o_RX_Byte !== 8'h00) begin n_errors++; $display("FAIL reset_byte: got %h want 00", rx_if.o_RX_Byte); end
    dv0 = dv_cnt;
    err0 = err_cnt;
    rst = 1'b0;
    idle(4 * CPB);
    n_checks++;
    if (dv_cnt - dv0 != 0 || err_cnt - err0 != 0) begin
      n_errors++;
      $display("FAIL reset_quiet: dv=%0d err=%0d pulses want 0/0", dv_cnt - dv0, err_cnt - err0);
    end
    n_checks++;
    if (rx_if.o_RX_Active !== 1'b0) begin n_errors++; $display("FAIL reset_idle_active: got %b want 0", rx_if.o_RX_Active); end
  endtask

  task automatic test_single();
    int dv0, err0, base, e0, alow, lat;
    dv0 = dv_cnt; err0 = err_cnt; base = obs_q.size();
    e0 = edge_cnt;
    send_frame(8'hA5, 1'b1, alow);
    idle(CPB);
    lat = dv_edge - e0;
    n_checks++;
    if (dv_cnt - dv0 != 1) begin n_errors++; $display("FAIL single_dv_count: got %0d want 1", dv_cnt - dv0); end
    n_checks++;
    if (err_cnt - err0 != 0) begin n_errors++; $display("FAIL single_err: got %0d want 0", err_cnt - err0); end
    n_checks++;
    if (obs_q.size() <= base || obs_q[base] !== 8'hA5) begin
      n_errors++;
      $display("FAIL single_byte: got %h want a5", (obs_q.size() > base) ? obs_q[base] : 8'hxx);
    end
    n_checks++;
    if (rx_if.o_RX_Byte !== 8'hA5) begin n_errors++; $display("FAIL single_hold: got %h want a5", rx_if.o_RX_Byte); end
    n_checks++;
    if (alow != 0) begin n_errors++; $display("FAIL single_active: low at %0d bit starts want 0", alow); end
    n_checks++;
    if (lat < LAT_NOM - 1 || lat > LAT_NOM + 1) begin
      n_errors++;
      $display("FAIL single_latency: got %0d want %0d+-1", lat, LAT_NOM);
    end
    n_checks++;
    if (rx_if.o_RX_Active !== 1'b0) begin n_errors++; $display("FAIL single_active_end: got %b want 0", rx_if.o_RX_Active); end
    last_good = 8'hA5;
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    int dv0, err0, base, alow;
    logic [7:0] e;
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h3C;
    dv0 = dv_cnt; err0 = err_cnt; base = obs_q.size();
    for (int i = 0; i < 3; i++) begin
      send_frame(bytes[i], 1'b1, alow);
      exp_q.push_back(bytes[i]);
    end
    idle(2 * CPB);
    n_checks++;
    if (dv_cnt - dv0 != 3) begin n_errors++; $display("FAIL b2b_dv_count: got %0d want 3", dv_cnt - dv0); end
    n_checks++;
    if (err_cnt - err0 != 0) begin n_errors++; $display("FAIL b2b_err: got %0d want 0", err_cnt - err0); end
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() <= base + i || obs_q[base + i] !== e) begin
        n_errors++;
        $display("FAIL b2b_byte%0d: got %h want %h", i, (obs_q.size() > base + i) ? obs_q[base + i] : 8'hxx, e);
      end
    end
    last_good = 8'h3C;
  endtask

  task automatic test_glitch();
    int dv0, err0, a0;
    dv0 = dv_cnt; err0 = err_cnt; a0 = active_hi_cnt;
    rx_if.i_RX_Serial = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    idle(4 * CPB);
    n_checks++;
    if (dv_cnt - dv0 != 0 || err_cnt - err0 != 0) begin
      n_errors++;
      $display("FAIL glitch_pulses: dv=%0d err=%0d want 0/0", dv_cnt - dv0, err_cnt - err0);
    end
    n_checks++;
    if (active_hi_cnt - a0 != 0) begin n_errors++; $display("FAIL glitch_active: high %0d cycles want 0", active_hi_cnt - a0); end
  endtask

  task automatic test_frame_err();
    int dv0, err0, base, alow;
    dv0 = dv_cnt; err0 = err_cnt;
    send_frame(8'h55, 1'b0, alow);
    rx_if.i_RX_Serial = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    n_checks++;
    if (err_cnt - err0 != 1) begin n_errors++; $display("FAIL ferr_count: got %0d want 1", err_cnt - err0); end
    n_checks++;
    if (dv_cnt - dv0 != 0) begin n_errors++; $display("FAIL ferr_dv: got %0d want 0", dv_cnt - dv0); end
    n_checks++;
    if (rx_if.o_RX_Byte !== last_good) begin n_errors++; $display("FAIL ferr_byte_kept: got %h want %h", rx_if.o_RX_Byte, last_good); end
    idle(2 * CPB);
    n_checks++;
    if (err_cnt - err0 != 1 || dv_cnt - dv0 != 0) begin
      n_errors++;
      $display("FAIL ferr_no_rearm: err=%0d dv=%0d want 1/0", err_cnt - err0, dv_cnt - dv0);
    end
    base = obs_q.size();
    send_frame(8'h81, 1'b1, alow);
    idle(CPB);
    n_checks++;
    if (obs_q.size() != base + 1 || obs_q[base] !== 8'h81) begin
      n_errors++;
      $display("FAIL ferr_next_frame: got %0d bytes, first %h want 1 byte 81", obs_q.size() - base,
               (obs_q.size() > base) ? obs_q[base] : 8'hxx);
    end
    last_good = 8'h81;
  endtask

  task automatic test_reset_mid();
    int dv0, err0, base, alow;
    logic [7:0] d;
    d = 8'($urandom_range(0, 255));
    dv0 = dv_cnt; err0 = err_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx_if.i_RX_Serial = d[4];
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (rx_if.o_RX_Active !== 1'b0 || rx_if.o_RX_DV !== 1'b0 || rx_if.o_RX_Frame_Err !== 1'b0) begin
      n_errors++;
      $display("FAIL midrst_flags: active=%b dv=%b err=%b want 0/0/0", rx_if.o_RX_Active, rx_if.o_RX_DV, rx_if.o_RX_Frame_Err);
    end
    n_checks++;
    if (rx_if.o_RX_Byte !== 8'h00) begin n_errors++; $display("FAIL midrst_byte: got %h want 00", rx_if.o_RX_Byte); end
    rst = 1'b0;
    idle(3 * CPB);
    n_checks++;
    if (dv_cnt - dv0 != 0 || err_cnt - err0 != 0) begin
      n_errors++;
      $display("FAIL midrst_pulses: dv=%0d err=%0d want 0/0", dv_cnt - dv0, err_cnt - err0);
    end
    base = obs_q.size();
    send_frame(8'h7E, 1'b1, alow);
    idle(CPB);
    n_checks++;
    if (obs_q.size() != base + 1 || obs_q[base] !== 8'h7E) begin
      n_errors++;
      $display("FAIL midrst_next_frame: got %0d bytes, first %h want 1 byte 7e", obs_q.size() - base,
               (obs_q.size() > base) ? obs_q[base] : 8'hxx);
    end
    last_good = 8'h7E;
  endtask

  task automatic test_random();
    int dv0, err0, base, alow, alow_tot, exp_err, n_exp;
    logic [7:0] d, e;
    logic bad;
    dv0 = dv_cnt; err0 = err_cnt; base = obs_q.size();
    alow_tot = 0; exp_err = 0;
    for (int f = 0; f < 24; f++) begin
      d = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 4) == 0);
      send_frame(d, !bad, alow);
      alow_tot += alow;
      if (bad) begin
        exp_err++;
        rx_if.i_RX_Serial = 1'b0;
        repeat ($urandom_range(0, CPB)) @(posedge clk);
        #1;
        idle(CPB + $urandom_range(0, CPB));
      end else begin
        exp_q.push_back(d);
        last_good = d;
        if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2 * CPB));
      end
    end
    idle(2 * CPB);
    n_exp = exp_q.size();
    n_checks++;
    if (dv_cnt - dv0 != n_exp) begin n_errors++; $display("FAIL rand_dv_count: got %0d want %0d", dv_cnt - dv0, n_exp); end
    n_checks++;
    if (err_cnt - err0 != exp_err) begin n_errors++; $display("FAIL rand_err_count: got %0d want %0d", err_cnt - err0, exp_err); end
    n_checks++;
    if (alow_tot != 0) begin n_errors++; $display("FAIL rand_active: low at %0d bit starts want 0", alow_tot); end
    for (int i = 0; i < n_exp; i++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() <= base + i || obs_q[base + i] !== e) begin
        n_errors++;
        $display("FAIL rand_byte%0d: got %h want %h", i, (obs_q.size() > base + i) ? obs_q[base + i] : 8'hxx, e);
      end
    end
    n_checks++;
    if (rx_if.o_RX_Byte !== last_good) begin n_errors++; $display("FAIL rand_last_byte: got %h want %h", rx_if.o_RX_Byte, last_good); end
  endtask

  task automatic test_exclusive();
    n_checks++;
    if (both_cnt != 0) begin n_errors++; $display("FAIL dv_err_overlap: %0d cycles want 0", both_cnt); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rx_if.i_RX_Serial = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_random();
    test_exclusive();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
